// File: rtl/operand_sequencer_if.sv
// Valid/ready bundle for the operand sequencer: operand pair in, captured results out.
// The slave modport is the sequencer's view; master is the upstream/downstream peer.
interface operand_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_first;
  logic [3:0] out_second;
  logic [4:0] out_sum;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_first, out_second, out_sum
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_first, out_second, out_sum
  );
endinterface

// File: rtl/operand_sequencer.sv
// Latches an operand pair, steers it through an external 2:1 mux one select at a time,
// and returns both captured mux outputs plus their 5-bit sum over a valid/ready handshake.
module operand_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  operand_sequencer_if.slave bus,
  output logic [3:0]         mux_a,
  output logic [3:0]         mux_b,
  output logic               mux_sel,
  input  logic [3:0]         mux_o,
  output logic [CNT_W-1:0]   txn_count
);

  typedef enum logic [1:0] {StIdle, StSelA, StSelB, StDone} state_e;

  state_e           state_q;
  logic [3:0]       op_a_q;
  logic [3:0]       op_b_q;
  logic [3:0]       first_q;
  logic [3:0]       second_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             mux_sel_q;
  logic [CNT_W-1:0] count_q;

  // Handshake and select outputs are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      first_q     <= '0;
      second_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mux_sel_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_a_q     <= bus.in_a;
            op_b_q     <= bus.in_b;
            in_ready_q <= 1'b0;
            mux_sel_q  <= 1'b0;
            state_q    <= StSelA;
          end
        end
        StSelA: begin
          first_q   <= mux_o;
          mux_sel_q <= 1'b1;
          state_q   <= StSelB;
        end
        StSelB: begin
          second_q    <= mux_o;
          mux_sel_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            count_q     <= count_q + 1'b1;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_first  = first_q;
  assign bus.out_second = second_q;
  assign bus.out_sum    = {1'b0, first_q} + {1'b0, second_q};

  assign mux_a     = op_a_q;
  assign mux_b     = op_b_q;
  assign mux_sel   = mux_sel_q;
  assign txn_count = count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomised self-checking bench for operand_sequencer with a behavioural mux model
// and a transaction-level reference (expected results from operands, count modulo 2^CNT_W).
module tb_operand_sequencer;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       mux_a;
  logic [3:0]       mux_b;
  logic             mux_sel;
  logic [3:0]       mux_o;
  logic [CNT_W-1:0] txn_count;
  logic             force5;

  int total = 0;
  int bad = 0;
  int model_count = 0;

  operand_sequencer_if bus ();

  operand_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mux_a     (mux_a),
    .mux_b     (mux_b),
    .mux_sel   (mux_sel),
    .mux_o     (mux_o),
    .txn_count (txn_count)
  );

  // Ideal 2:1 mux, optionally stuck at a constant to prove capture comes from mux_o.
  assign mux_o = force5 ? 4'd5 : (mux_sel ? mux_b : mux_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int next_count(input int c);
    return (c + 1) % (1 << CNT_W);
  endfunction

  // Runs one transaction; returns captured results, cycles from accept to out_valid, timeout.
  task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input int stall,
                        output logic [3:0] f, output logic [3:0] s, output logic [4:0] sm,
                        output int lat, output bit to);
    int n;
    to = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) to = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) to = 1'b1;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    f  = bus.out_first;
    s  = bus.out_second;
    sm = bus.out_sum;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    model_count = next_count(model_count);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 4'($urandom);
    bus.in_b      = 4'($urandom);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    model_count = 0;
    total++;
    if ({bus.in_ready, bus.out_valid, mux_sel} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 100", {bus.in_ready, bus.out_valid, mux_sel});
    end
    total++;
    if ({mux_a, mux_b} !== 8'h00) begin
      bad++;
      $display("FAIL reset_mux: got %h want 00", {mux_a, mux_b});
    end
    total++;
    if ({bus.out_first, bus.out_second} !== 8'h00 || bus.out_sum !== 5'd0) begin
      bad++;
      $display("FAIL reset_results: got %h/%0d want 00/0", {bus.out_first, bus.out_second},
               bus.out_sum);
    end
    total++;
    if (txn_count !== '0) begin
      bad++;
      $display("FAIL reset_count: got %0d want 0", txn_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    bus.in_a     = 4'd7;
    bus.in_b     = 4'd11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (mux_sel !== 1'b1) begin
      bad++;
      $display("FAIL midrst_selb: got mux_sel=%b want 1", mux_sel);
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    total++;
    if ({bus.in_ready, bus.out_valid, mux_sel, mux_a, mux_b} !== {3'b100, 8'h00}) begin
      bad++;
      $display("FAIL midrst_ctrl: got %b %h want 100 00", {bus.in_ready, bus.out_valid, mux_sel},
               {mux_a, mux_b});
    end
    total++;
    if ({bus.out_first, bus.out_second, bus.out_sum} !== 13'd0 || txn_count !== '0) begin
      bad++;
      $display("FAIL midrst_state: got %0d %0d %0d cnt=%0d want 0 0 0 cnt=0", bus.out_first,
               bus.out_second, bus.out_sum, txn_count);
    end
    model_count = 0;
  endtask

  task automatic test_basic();
    bus.in_valid = 1'b1;
    bus.in_a     = 4'd3;
    bus.in_b     = 4'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++;
    if ({mux_sel, bus.in_ready, mux_a, mux_b} !== {2'b00, 4'd3, 4'd9}) begin
      bad++;
      $display("FAIL basic_sela: got sel=%b rdy=%b a=%0d b=%0d want 0 0 3 9", mux_sel,
               bus.in_ready, mux_a, mux_b);
    end
    @(posedge clk); #1;
    total++;
    if (mux_sel !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_selb: got sel=%b vld=%b want 1 0", mux_sel, bus.out_valid);
    end
    @(posedge clk); #1;
    total++;
    if ({bus.out_valid, mux_sel, bus.out_first, bus.out_second, bus.out_sum}
        !== {2'b10, 4'd3, 4'd9, 5'd12}) begin
      bad++;
      $display("FAIL basic_done: got vld=%b sel=%b %0d %0d %0d want 1 0 3 9 12", bus.out_valid,
               mux_sel, bus.out_first, bus.out_second, bus.out_sum);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    model_count = next_count(model_count);
    total++;
    if (txn_count !== CNT_W'(1) || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_count: got cnt=%0d rdy=%b vld=%b want 1 1 0", txn_count,
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_corners();
    logic [3:0] f, s;
    logic [4:0] sm;
    int lat;
    bit to;
    logic [3:0] va [2] = '{4'd15, 4'd0};
    for (int i = 0; i < 2; i++) begin
      do_txn(va[i], va[i], 0, f, s, sm, lat, to);
      total++;
      if (to || f !== va[i] || s !== va[i] || int'(sm) != 2 * int'(va[i])) begin
        bad++;
        $display("FAIL corner_sum: got %0d+%0d=%0d to=%b want %0d+%0d=%0d", f, s, sm, to,
                 va[i], va[i], 2 * int'(va[i]));
      end
      total++;
      if (int'(txn_count) != model_count) begin
        bad++;
        $display("FAIL corner_count: got %0d want %0d", txn_count, model_count);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] a, b;
    a = 4'($urandom);
    b = 4'($urandom);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 4'($urandom);
      bus.in_b     = 4'($urandom);
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.in_ready, bus.out_first, bus.out_second, mux_a, mux_b}
          !== {2'b10, a, b, a, b} || int'(bus.out_sum) != int'(a) + int'(b)
          || int'(txn_count) != model_count) begin
        bad++;
        $display("FAIL stall_hold: cyc=%0d got v=%b r=%b %0d %0d %0d m=%0d/%0d c=%0d want %0d %0d",
                 i, bus.out_valid, bus.in_ready, bus.out_first, bus.out_second, bus.out_sum,
                 mux_a, mux_b, txn_count, a, b);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    model_count = next_count(model_count);
    total++;
    if (int'(txn_count) != model_count || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: got cnt=%0d rdy=%b want %0d 1", txn_count, bus.in_ready,
               model_count);
    end
  endtask

  task automatic test_random();
    logic [3:0] a, b, f, s;
    logic [4:0] sm;
    int lat;
    bit to;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      do_txn(a, b, $urandom_range(0, 3), f, s, sm, lat, to);
      total++;
      if (to || lat != 2) begin
        bad++;
        $display("FAIL rand_latency: got lat=%0d to=%b want 2 0", lat, to);
      end
      total++;
      if (f !== a || s !== b || int'(sm) != int'(a) + int'(b)) begin
        bad++;
        $display("FAIL rand_result: got %0d %0d %0d want %0d %0d %0d", f, s, sm, a, b,
                 int'(a) + int'(b));
      end
      total++;
      if (int'(txn_count) != model_count) begin
        bad++;
        $display("FAIL rand_count: got %0d want %0d", txn_count, model_count);
      end
    end
  endtask

  task automatic test_const_mux();
    logic [3:0] f, s;
    logic [4:0] sm;
    int lat;
    bit to;
    force5 = 1'b1;
    do_txn(4'd3, 4'd9, 0, f, s, sm, lat, to);
    total++;
    if (to || f !== 4'd5 || s !== 4'd5 || sm !== 5'd10) begin
      bad++;
      $display("FAIL const_mux: got %0d %0d %0d want 5 5 10", f, s, sm);
    end
    force5 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b, f, s;
    logic [4:0] sm;
    int lat;
    bit to;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_count = 0;
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      do_txn(a, b, 0, f, s, sm, lat, to);
      total++;
      if (to || int'(sm) != int'(a) + int'(b)) begin
        bad++;
        $display("FAIL b2b_sum: txn=%0d got %0d to=%b want %0d", i, sm, to, int'(a) + int'(b));
      end
      total++;
      if (int'(txn_count) != model_count) begin
        bad++;
        $display("FAIL b2b_count: txn=%0d got %0d want %0d", i, txn_count, model_count);
      end
      if (i == (1 << CNT_W) - 1) begin
        total++;
        if (txn_count !== '0) begin
          bad++;
          $display("FAIL b2b_wrap: got %0d want 0", txn_count);
        end
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    force5        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_reset_mid();
    test_basic();
    test_corners();
    test_backpressure();
    test_random();
    test_const_mux();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
